sram_responder: RTL

- Responder end of the CPU RAM interface. Accepts single-byte read/write requests from the System initiator and sequences them onto an external asynchronous 8-bit SRAM.
- Generates the SRAM timing: address setup, OE/WE pulse widths and write data hold.
- Returns read data with a one-cycle acknowledge.
- Sits between the System instance and the top-level SRAM pins. The top level owns the tristate: the SRAM data bus is driven with oSramD when oSramDOe=1 and is high-impedance otherwise.

---
 rtl/sram_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// Responder end of the CPU RAM interface: sequences single-byte read/write
// requests onto an asynchronous 8-bit SRAM with fully registered pin timing.
module sram_responder #(
    parameter int ADDR_W   = 20,
    parameter int SRAM_A_W = 18,
    parameter int RD_WAIT  = 2,
    parameter int WR_WAIT  = 2
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [ADDR_W-1:0]   iReqAddr,
    input  logic [7:0]          iReqDataW,
    input  logic                iReqR,
    input  logic                iReqW,
    output logic                oBusy,
    output logic                oAck,
    output logic [7:0]          oReqDataR,
    output logic [SRAM_A_W-1:0] oSramA,
    output logic [7:0]          oSramD,
    output logic                oSramDOe,
    input  logic [7:0]          iSramD,
    output logic                oSramCe_n,
    output logic                oSramOe_n,
    output logic                oSramWe_n
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    // The counter holds "remaining cycles minus one", reloaded on every state entry.
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WSETUP,
        ST_WPULSE,
        ST_WHOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SRAM_A_W-1:0] addr_d;
    logic [7:0]          wdata_d;
    logic [7:0]          rdata_d;
    logic                ack_d;

    // Upper request address bits are dropped on purpose, so addresses alias.
    if (ADDR_W > SRAM_A_W) begin : g_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^iReqAddr[ADDR_W-1:SRAM_A_W];
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = oSramA;
        wdata_d = oSramD;
        rdata_d = oReqDataR;
        ack_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (iReqW) begin
                    state_d = ST_WSETUP;
                    addr_d  = iReqAddr[SRAM_A_W-1:0];
                    wdata_d = iReqDataW;
                end else if (iReqR) begin
                    state_d = ST_RD;
                    addr_d  = iReqAddr[SRAM_A_W-1:0];
                    cnt_d   = RD_LOAD;
                end
            end
            ST_RD: begin
                if (cnt_q == '0) begin
                    rdata_d = iSramD;
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WSETUP: begin
                state_d = ST_WPULSE;
                cnt_d   = WR_LOAD;
            end
            ST_WPULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_WHOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WHOLD: begin
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so every output is a flop.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            oBusy     <= 1'b0;
            oAck      <= 1'b0;
            oReqDataR <= '0;
            oSramA    <= '0;
            oSramD    <= '0;
            oSramDOe  <= 1'b0;
            oSramCe_n <= 1'b1;
            oSramOe_n <= 1'b1;
            oSramWe_n <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so all flops update together from pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            oBusy     <= (state_d != ST_IDLE);
            oAck      <= ack_d;
            oReqDataR <= rdata_d;
            oSramA    <= addr_d;
            oSramD    <= wdata_d;
            oSramDOe  <= (state_d == ST_WSETUP) || (state_d == ST_WPULSE) || (state_d == ST_WHOLD);
            oSramCe_n <= (state_d == ST_IDLE);
            oSramOe_n <= (state_d != ST_RD);
            oSramWe_n <= (state_d != ST_WPULSE);
        end
    end

endmodule
